// File: rtl/kiwi_main_bus_glue_if.sv
// Main-CPU bus bundle for the Kiwi-class board glue.
//   master : Z80 side, drives address/data/strobes and the clock enable,
//            and receives read data, interrupt and wait request.
//   slave  : bus glue side.
interface kiwi_main_bus_glue_if;
    logic        cpu_cen;   // CPU clock enable
    logic [15:0] A;         // CPU address
    logic [7:0]  dout;      // CPU write data
    logic        mreq_n;
    logic        rfsh_n;
    logic        wr_n;
    logic        iorq_n;
    logic [7:0]  din;       // CPU read data (registered)
    logic        int_n;     // CPU interrupt
    logic        dev_busy;  // wait request

    modport master (
        output cpu_cen, A, dout, mreq_n, rfsh_n, wr_n, iorq_n,
        input  din, int_n, dev_busy
    );

    modport slave (
        input  cpu_cen, A, dout, mreq_n, rfsh_n, wr_n, iorq_n,
        output din, int_n, dev_busy
    );
endinterface

// File: rtl/kiwi_main_bus_glue.sv
// Main-CPU bus glue: memory-map decode into registered chip selects, read
// data mux, ROM bank / sound-reset register, VBLANK interrupt, and the
// dual-port shared RAM with first-come arbitration against the sub CPU.
// Ports:
//   clk, rst          : clock, async active-high reset
//   bus (slave)       : Z80 address/data/strobes, din, int_n, dev_busy
//   LVBL, dip_pause   : vertical blank (active low), interrupt enable
//   hcnt              : video H counter, used for VRAM wait slots
//   vram/vctrl/vflag/pal_cs, vram_dout, pal_dout : video block port
//   cpu_addr/cpu_dout/cpu_rnw : address/data/direction to video blocks
//   rom_addr, rom_cs, rom_data : banked program ROM
//   snd_rstn          : sound CPU reset (active low)
//   shr_*, sub_rnw    : sub-CPU port of the shared RAM
//   mshramen          : main CPU currently owns the shared RAM
//   st_dout           : status byte {3'b0, ~snd_rstn, 1'b0, bank}
module kiwi_main_bus_glue #(
    parameter int RAM_AW = 13
) (
    input  logic              clk,
    input  logic              rst,
    kiwi_main_bus_glue_if.slave bus,
    input  logic              LVBL,
    input  logic              dip_pause,
    input  logic [8:0]        hcnt,
    output logic              vram_cs,
    output logic              vctrl_cs,
    output logic              vflag_cs,
    output logic              pal_cs,
    input  logic [7:0]        vram_dout,
    input  logic [7:0]        pal_dout,
    output logic [12:0]       cpu_addr,
    output logic [7:0]        cpu_dout,
    output logic              cpu_rnw,
    output logic [16:0]       rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    output logic              snd_rstn,
    input  logic [RAM_AW-1:0] shr_addr,
    input  logic [7:0]        shr_din,
    input  logic              sub_rnw,
    input  logic              shr_cs,
    output logic [7:0]        shr_dout,
    output logic              mshramen,
    output logic [7:0]        st_dout
);

    logic [15:0] a;
    logic        mem_acc;
    logic        ram_cs;
    logic        bank_cs;
    logic [2:0]  bank;
    logic        sshramen;
    logic        irq_trig;
    logic        irq_last;
    logic        int_n_r;
    logic [7:0]  din_r;
    logic [7:0]  ram_q0;
    logic        obj_vram_en;
    logic        we0;
    logic        we1;
    logic        unused_bits;

    logic [7:0]  mem [0:(2**RAM_AW)-1];

    assign a       = bus.A;
    assign mem_acc = ~bus.mreq_n & bus.rfsh_n;

    assign cpu_addr = a[12:0];
    assign cpu_dout = bus.dout;
    assign cpu_rnw  = bus.wr_n | ~bus.cpu_cen;

    // Upper half of the map is banked in 16 KB windows; lower 32 KB is fixed.
    assign rom_addr = a[15] ? {bank, a[13:0]} : {2'b00, a[14], a[13:0]};
    assign st_dout  = {3'b000, ~snd_rstn, 1'b0, bank};

    assign bus.din   = din_r;
    assign bus.int_n = int_n_r;

    // Video memories are only reachable in the hcnt slots where the video
    // side is not fetching; otherwise the CPU is held.
    assign obj_vram_en = mem_acc & (((a[15:11] == 5'b11110) & ~a[9]) |
                                    (a[15:10] == 6'b111100) |
                                    (a[15:13] == 3'b110));
    assign bus.dev_busy = (sshramen & ram_cs) | (obj_vram_en & (hcnt[1:0] != 2'b00));

    assign unused_bits = ^{1'b0, hcnt[8:2]};

    // Registered chip selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_cs   <= 1'b0;
            vram_cs  <= 1'b0;
            ram_cs   <= 1'b0;
            vctrl_cs <= 1'b0;
            vflag_cs <= 1'b0;
            bank_cs  <= 1'b0;
            pal_cs   <= 1'b0;
        end else begin
            rom_cs   <= mem_acc & (a[15:12] < 4'hC);
            vram_cs  <= mem_acc & (a[15:13] == 3'b110);
            ram_cs   <= mem_acc & (a[15:12] == 4'hE);
            vctrl_cs <= mem_acc & (a[15:10] == 6'b111100);
            vflag_cs <= mem_acc & (a[15:9] == 7'b1111010) & ~bus.wr_n;
            bank_cs  <= mem_acc & (a[15:9] == 7'b1111011) & ~bus.wr_n;
            pal_cs   <= mem_acc & (a[15:11] == 5'b11111);
        end
    end

    // Read data mux, first match wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r <= 8'h00;
        end else if (rom_cs) begin
            din_r <= rom_data;
        end else if (ram_cs) begin
            din_r <= ram_q0;
        end else if (vram_cs | vctrl_cs) begin
            din_r <= vram_dout;
        end else if (pal_cs) begin
            din_r <= pal_dout;
        end else begin
            din_r <= 8'h00;
        end
    end

    // Bank / sound reset register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank     <= 3'd0;
            snd_rstn <= 1'b0;
        end else if (bank_cs) begin
            bank     <= bus.dout[2:0];
            snd_rstn <= bus.dout[4];
        end
    end

    // VBLANK interrupt. Any IORQ cycle acknowledges (M1 is not decoded on the
    // board), and an acknowledge beats a coincident new edge.
    assign irq_trig = ~LVBL & dip_pause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_n_r  <= 1'b1;
            irq_last <= 1'b0;
        end else begin
            irq_last <= irq_trig;
            if (!bus.iorq_n) begin
                int_n_r <= 1'b1;
            end else if (irq_trig & ~irq_last) begin
                int_n_r <= 1'b0;
            end
        end
    end

    // First-come arbitration; the main side is checked against the
    // registered ram_cs so it wins a same-clock request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mshramen <= 1'b0;
            sshramen <= 1'b0;
        end else begin
            if (ram_cs & ~sshramen) begin
                mshramen <= 1'b1;
            end else if (!ram_cs) begin
                mshramen <= 1'b0;
            end
            if (shr_cs & ~mshramen & ~ram_cs) begin
                sshramen <= 1'b1;
            end else if (!shr_cs) begin
                sshramen <= 1'b0;
            end
        end
    end

    // Shared RAM. Arbitration never grants both writers at once, so both
    // write ports can live in one process without an ordering hazard.
    assign we0 = mshramen & ~bus.wr_n;
    assign we1 = sshramen & ~sub_rnw;

    always_ff @(posedge clk) begin
        if (we0) begin
            mem[a[RAM_AW-1:0]] <= bus.dout;
        end
        if (we1) begin
            mem[shr_addr] <= shr_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_q0   <= 8'h00;
            shr_dout <= 8'h00;
        end else begin
            ram_q0   <= mem[a[RAM_AW-1:0]];
            shr_dout <= mem[shr_addr];
        end
    end

endmodule

// File: tb/tb_kiwi_main_bus_glue.sv
module tb_kiwi_main_bus_glue;

    logic        clk;
    logic        rst;
    logic        LVBL;
    logic        dip_pause;
    logic [8:0]  hcnt;
    logic        vram_cs, vctrl_cs, vflag_cs, pal_cs;
    logic [7:0]  vram_dout, pal_dout;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw;
    logic [16:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        snd_rstn;
    logic [12:0] shr_addr;
    logic [7:0]  shr_din;
    logic        sub_rnw;
    logic        shr_cs;
    logic [7:0]  shr_dout;
    logic        mshramen;
    logic [7:0]  st_dout;

    int checks;
    int errors;

    kiwi_main_bus_glue_if bus();

    kiwi_main_bus_glue #(.RAM_AW(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .LVBL      (LVBL),
        .dip_pause (dip_pause),
        .hcnt      (hcnt),
        .vram_cs   (vram_cs),
        .vctrl_cs  (vctrl_cs),
        .vflag_cs  (vflag_cs),
        .pal_cs    (pal_cs),
        .vram_dout (vram_dout),
        .pal_dout  (pal_dout),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_rnw   (cpu_rnw),
        .rom_addr  (rom_addr),
        .rom_cs    (rom_cs),
        .rom_data  (rom_data),
        .snd_rstn  (snd_rstn),
        .shr_addr  (shr_addr),
        .shr_din   (shr_din),
        .sub_rnw   (sub_rnw),
        .shr_cs    (shr_cs),
        .shr_dout  (shr_dout),
        .mshramen  (mshramen),
        .st_dout   (st_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic        wr_n;
        logic        rfsh_n;
        logic [8:0]  hcnt;
        logic [6:0]  exp_sel;      // {rom, vram, vctrl, vflag, pal, msh, busy}
        logic [16:0] exp_rom_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{"dec_c000",  16'hC000, 1'b1, 1'b1, 9'd0, 7'b0100000, 17'h0C000};
        vecs[1] = '{"dec_f000",  16'hF000, 1'b1, 1'b1, 9'd2, 7'b0010001, 17'h0F000};
        vecs[2] = '{"dec_f400w", 16'hF400, 1'b0, 1'b1, 9'd0, 7'b0001000, 17'h0F400};
        vecs[3] = '{"dec_f800",  16'hF800, 1'b1, 1'b1, 9'd3, 7'b0000100, 17'h0F800};
        vecs[4] = '{"dec_e000",  16'hE000, 1'b1, 1'b1, 9'd0, 7'b0000010, 17'h0E000};
        vecs[5] = '{"vram_h1",   16'hD000, 1'b1, 1'b1, 9'd1, 7'b0100001, 17'h0D000};
        vecs[6] = '{"vram_h4",   16'hD000, 1'b1, 1'b1, 9'd4, 7'b0100000, 17'h0D000};
        vecs[7] = '{"rfsh",      16'hC000, 1'b1, 1'b0, 9'd1, 7'b0000000, 17'h0C000};
        vecs[8] = '{"rom_8123",  16'h8123, 1'b1, 1'b1, 9'd0, 7'b1000000, 17'h0C123};
        vecs[9] = '{"rom_4123",  16'h4123, 1'b1, 1'b1, 9'd0, 7'b1000000, 17'h04123};

        rst = 1'b1;
        bus.cpu_cen = 1'b1;
        bus.A = 16'h0000;
        bus.dout = 8'h00;
        bus.mreq_n = 1'b1;
        bus.rfsh_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.iorq_n = 1'b1;
        LVBL = 1'b1;
        dip_pause = 1'b1;
        hcnt = 9'd0;
        vram_dout = 8'hD5;
        pal_dout = 8'hBA;
        rom_data = 8'h00;
        shr_addr = 13'h0;
        shr_din = 8'h00;
        sub_rnw = 1'b1;
        shr_cs = 1'b0;

        #2;
        chk("rst_int_n", {31'b0, bus.int_n}, 32'h1);
        chk("rst_st_dout", {24'b0, st_dout}, 32'h10);
        chk("rst_outs", {26'b0, rom_cs, vram_cs, mshramen, snd_rstn, bus.dev_busy, vflag_cs}, 32'h0);
        chk("rst_din", {24'b0, bus.din}, 32'h0);
        chk("cpu_rnw_rd", {31'b0, cpu_rnw}, 32'h1);
        #20;
        rst = 1'b0;
        tick(1);

        // Bank register write
        bus.A = 16'hF600; bus.dout = 8'h13; bus.mreq_n = 1'b0; bus.wr_n = 1'b0;
        #1;
        chk("cpu_rnw_wr", {31'b0, cpu_rnw}, 32'h0);
        tick(2);
        chk("bank_st_dout", {24'b0, st_dout}, 32'h03);
        chk("bank_snd_rstn", {31'b0, snd_rstn}, 32'h1);
        bus.wr_n = 1'b1;

        // Decode table
        for (int i = 0; i < 10; i++) begin
            bus.A = vecs[i].a;
            bus.wr_n = vecs[i].wr_n;
            bus.rfsh_n = vecs[i].rfsh_n;
            hcnt = vecs[i].hcnt;
            tick(2);
            chk({vecs[i].name, "_sel"},
                {25'b0, rom_cs, vram_cs, vctrl_cs, vflag_cs, pal_cs, mshramen, bus.dev_busy},
                {25'b0, vecs[i].exp_sel});
            chk({vecs[i].name, "_romaddr"}, {15'b0, rom_addr}, {15'b0, vecs[i].exp_rom_addr});
        end
        bus.wr_n = 1'b1; bus.rfsh_n = 1'b1; hcnt = 9'd0;

        // ROM read data registered one clk after rom_cs
        rom_data = 8'h3C;
        tick(1);
        chk("rom_din", {24'b0, bus.din}, 32'h3C);

        // Shared RAM: main write, sub read
        bus.A = 16'hE010; bus.dout = 8'h5A; bus.wr_n = 1'b0; bus.mreq_n = 1'b0;
        tick(3);
        bus.wr_n = 1'b1; bus.mreq_n = 1'b1;
        tick(2);
        shr_cs = 1'b1; shr_addr = 13'h010; sub_rnw = 1'b1;
        tick(3);
        chk("shr_rd_5a", {24'b0, shr_dout}, 32'h5A);

        // Sub write, main read
        shr_addr = 13'h020; shr_din = 8'hA5; sub_rnw = 1'b0;
        tick(1);
        sub_rnw = 1'b1; shr_cs = 1'b0;
        tick(1);
        bus.A = 16'hE020; bus.mreq_n = 1'b0; bus.wr_n = 1'b1;
        tick(3);
        chk("main_rd_a5", {24'b0, bus.din}, 32'hA5);

        // Contention: main and sub request on the same clk, main wins
        bus.mreq_n = 1'b1;
        tick(2);
        bus.A = 16'hE000; bus.mreq_n = 1'b0;
        tick(1);
        shr_cs = 1'b1;
        tick(1);
        chk("cont_msh", {31'b0, mshramen}, 32'h1);
        chk("cont_busy", {31'b0, bus.dev_busy}, 32'h0);

        // Sub owns RAM; main access is held off until the sub releases
        bus.mreq_n = 1'b1;
        tick(3);
        bus.mreq_n = 1'b0;
        tick(2);
        chk("held_busy", {31'b0, bus.dev_busy}, 32'h1);
        chk("held_msh", {31'b0, mshramen}, 32'h0);
        shr_cs = 1'b0;
        tick(1);
        chk("release_busy", {31'b0, bus.dev_busy}, 32'h0);
        tick(1);
        chk("release_msh", {31'b0, mshramen}, 32'h1);
        bus.mreq_n = 1'b1;
        tick(2);

        // Interrupt
        LVBL = 1'b0;
        tick(1);
        chk("irq_set", {31'b0, bus.int_n}, 32'h0);
        tick(1);
        chk("irq_hold", {31'b0, bus.int_n}, 32'h0);
        bus.iorq_n = 1'b0;
        tick(1);
        bus.iorq_n = 1'b1;
        chk("irq_ack", {31'b0, bus.int_n}, 32'h1);
        tick(1);
        chk("irq_no_retrig", {31'b0, bus.int_n}, 32'h1);
        LVBL = 1'b1;
        tick(2);
        // Acknowledge coinciding with a new edge wins
        LVBL = 1'b0; bus.iorq_n = 1'b0;
        tick(1);
        bus.iorq_n = 1'b1;
        chk("irq_ack_prio", {31'b0, bus.int_n}, 32'h1);
        LVBL = 1'b1;
        tick(2);
        dip_pause = 1'b0; LVBL = 1'b0;
        tick(2);
        chk("irq_paused", {31'b0, bus.int_n}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
